jhash_core: RTL and testbench
=============================

Name: jhash_core

Overview:
- Consumer end of the jhash stream interface: accepts 3x32-bit word triples from the stream producer, acknowledges each one, and runs the Jenkins lookup3 mix on internal state a/b/c.
- On end-of-message it runs the lookup3 final, writes one 64-bit result word {b,c} into the output FIFO, then re-arms for the next message.
- Sits between the stream producer and the result FIFO in the jhash datapath.

Parameters:
- none; constants live in jhash_pkg.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  block enable; low freezes FSM, counters, a/b/c and all handshakes
- initval  in  32  seed; loaded into a, b and c at reset and at re-arm
- stream_data0  in  32  word added to a
- stream_data1  in  32  word added to b
- stream_data2  in  32  word added to c
- stream_valid  in  1  triple present on stream_data0..2
- stream_done  in  1  level, message finished (registered m_last)
- stream_ack  out  1  1-cycle pulse, triple consumed this cycle
- fo  out  64  result word {b[31:0], c[31:0]}
- fo_wen  out  1  1-cycle write strobe into result FIFO
- fo_full  in  1  result FIFO full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, step=0, a=b=c=initval, stream_ack=0, fo_wen=0, fo=0, busy=0. rst wins over every other event, including mid-MIX, mid-FINAL and OUT with fo_full; any partial hash is discarded.
- All arithmetic is mod 2^32; rot(x,k) = 32-bit rotate left by k.
- All state updates are gated by ce; with ce=0 nothing changes and stream_ack and fo_wen stay 0.
- FSM states: IDLE, MIX, FINAL, OUT, WAITCLR.
- IDLE, stream_valid=1 (accept; takes priority over stream_done):
  - stream_ack=1 this cycle.
  - Registers: a+=d0, b+=d1, c+=d2.
  - Go to MIX with step=0.
- IDLE, stream_valid=0 and stream_done=1: go to FINAL with step=0.
- MIX: one sub-step per cycle, step 0..5:
  - 0: a-=c; a^=rot(c,4); c+=b
  - 1: b-=a; b^=rot(a,6); a+=c
  - 2: c-=b; c^=rot(b,8); b+=a
  - 3: a-=c; a^=rot(c,16); c+=b
  - 4: b-=a; b^=rot(a,19); a+=c
  - 5: c-=b; c^=rot(b,4); b+=a
  - After step 5, return to IDLE.
  - Accept at cycle T gives MIX at T+1..T+6, IDLE at T+7, next possible ack at T+7.
  - Sustained throughput: 1 triple per 7 cycles.
- FINAL: step 0..6:
  - 0: c^=b; c-=rot(b,14)
  - 1: a^=c; a-=rot(c,11)
  - 2: b^=a; b-=rot(a,25)
  - 3: c^=b; c-=rot(b,16)
  - 4: a^=c; a-=rot(c,4)
  - 5: b^=a; b-=rot(a,14)
  - 6: c^=b; c-=rot(b,24)
  - Then go to OUT.
- OUT:
  - fo is driven {b,c} continuously.
  - If fo_full=0: fo_wen=1 for exactly one cycle, then a=b=c=initval and go to WAITCLR.
  - If fo_full=1: hold, no strobe, no data loss.
  - Trigger at T gives fo_wen at the earliest at T+8.
- WAITCLR:
  - Waits for stream_done=0, then goes to IDLE; this prevents re-triggering on the same level.
  - stream_valid is never acked in WAITCLR, MIX, FINAL or OUT; the producer holds its data.
- stream_done rising while in MIX: the current triple completes first; final starts from IDLE.
- Subexpression ordering within a sub-step is strictly as listed; each sub-step uses the register values from the start of that cycle.

Decomposition:
- jhash_pkg holds:
  - state encoding: IDLE=0, MIX=1, FINAL=2, OUT=3, WAITCLR=4
  - rotate constants for MIX (4,6,8,16,19,4) and FINAL (14,11,25,16,4,14,24)
  - step widths
  - rotl function
- Sub-module jhash_step: combinational, takes a/b/c, mode (mix/final) and step, returns next a/b/c.
- jhash_core holds the FSM, the registers and both handshakes.

Test Plan:
- initval=0, stream_done pulses with no data -> FINAL of zeros, fo=64'h0, exactly one fo_wen, at trigger+8.
- initval=0, one triple {1,2,3} then stream_done -> one stream_ack; fo equals the golden lookup3 C model (add, mix, final) bit-exact; 7-cycle gap before the final trigger.
- Producer holds stream_valid high for 4 back-to-back triples -> acks exactly 7 cycles apart, 4 acks total; result matches the model.
- fo_full=1 held for 20 cycles at OUT -> fo_wen=0 and fo stable; fo_full drops -> single fo_wen; no duplicate write.
- ce=0 for 5 cycles mid-MIX -> a/b/c and step frozen; final result identical to a run with ce=1 throughout, delayed by 5 cycles.
- rst asserted at MIX step 3 -> next cycle IDLE, a=b=c=initval (0xdeadbeef), ack=0, fo_wen=0; a new message afterwards hashes correctly.

Source files
------------

// File: rtl/jhash_pkg.sv
// Shared constants, state encoding and helpers for the lookup3 hash core.
package jhash_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MIX     = 3'd1,
    FINAL   = 3'd2,
    OUT     = 3'd3,
    WAITCLR = 3'd4
  } state_t;

  localparam int STEP_W = 3;
  localparam logic [STEP_W-1:0] MIX_LAST   = 3'd5;
  localparam logic [STEP_W-1:0] FINAL_LAST = 3'd6;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] k);
    return (x << k) | (x >> (6'd32 - {1'b0, k}));
  endfunction

  function automatic logic [4:0] mix_rot(input logic [STEP_W-1:0] s);
    case (s)
      3'd0:    return 5'd4;
      3'd1:    return 5'd6;
      3'd2:    return 5'd8;
      3'd3:    return 5'd16;
      3'd4:    return 5'd19;
      default: return 5'd4;
    endcase
  endfunction

  function automatic logic [4:0] final_rot(input logic [STEP_W-1:0] s);
    case (s)
      3'd0:    return 5'd14;
      3'd1:    return 5'd11;
      3'd2:    return 5'd25;
      3'd3:    return 5'd16;
      3'd4:    return 5'd4;
      3'd5:    return 5'd14;
      default: return 5'd24;
    endcase
  endfunction

endpackage

// File: rtl/jhash_step.sv
// One lookup3 mix or final sub-step; each sub-step only rewrites one or two of a/b/c.
module jhash_step
  import jhash_pkg::*;
(
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic [31:0]       c,
  input  logic              final_mode,
  input  logic [STEP_W-1:0] step,
  output logic [31:0]       a_next,
  output logic [31:0]       b_next,
  output logic [31:0]       c_next
);

  always_comb begin
    a_next = a;
    b_next = b;
    c_next = c;
    if (!final_mode) begin
      case (step)
        3'd0, 3'd3: begin
          a_next = (a - c) ^ rotl(c, mix_rot(step));
          c_next = c + b;
        end
        3'd1, 3'd4: begin
          b_next = (b - a) ^ rotl(a, mix_rot(step));
          a_next = a + c;
        end
        3'd2, 3'd5: begin
          c_next = (c - b) ^ rotl(b, mix_rot(step));
          b_next = b + a;
        end
        default: ;
      endcase
    end else begin
      case (step)
        3'd0, 3'd3, 3'd6: c_next = (c ^ b) - rotl(b, final_rot(step));
        3'd1, 3'd4:       a_next = (a ^ c) - rotl(c, final_rot(step));
        3'd2, 3'd5:       b_next = (b ^ a) - rotl(a, final_rot(step));
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jhash_core.sv
// Stream consumer running lookup3 mix per word triple and final per message,
// emitting {b,c} into the result FIFO.
module jhash_core
  import jhash_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] initval,
  input  logic [31:0] stream_data0,
  input  logic [31:0] stream_data1,
  input  logic [31:0] stream_data2,
  input  logic        stream_valid,
  input  logic        stream_done,
  output logic        stream_ack,
  output logic [63:0] fo,
  output logic        fo_wen,
  input  logic        fo_full,
  output logic        busy
);

  state_t            state_reg, state_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [31:0]       a_reg, b_reg, c_reg;
  logic [31:0]       a_next, b_next, c_next;
  logic [31:0]       a_step, b_step, c_step;

  jhash_step u_step (
    .a          (a_reg),
    .b          (b_reg),
    .c          (c_reg),
    .final_mode (state_reg == FINAL),
    .step       (step_reg),
    .a_next     (a_step),
    .b_next     (b_step),
    .c_next     (c_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      a_reg     <= initval;
      b_reg     <= initval;
      c_reg     <= initval;
    end else if (ce) begin
      state_reg <= state_next;
      step_reg  <= step_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE: begin
        // A pending triple is absorbed before a finish request is honoured.
        if (stream_valid) begin
          a_next     = a_reg + stream_data0;
          b_next     = b_reg + stream_data1;
          c_next     = c_reg + stream_data2;
          state_next = MIX;
          step_next  = '0;
        end else if (stream_done) begin
          state_next = FINAL;
          step_next  = '0;
        end
      end
      MIX: begin
        a_next = a_step;
        b_next = b_step;
        c_next = c_step;
        if (step_reg == MIX_LAST) begin
          state_next = IDLE;
          step_next  = '0;
        end else begin
          step_next = step_reg + 3'd1;
        end
      end
      FINAL: begin
        a_next = a_step;
        b_next = b_step;
        c_next = c_step;
        if (step_reg == FINAL_LAST) begin
          state_next = OUT;
          step_next  = '0;
        end else begin
          step_next = step_reg + 3'd1;
        end
      end
      OUT: begin
        if (!fo_full) begin
          a_next     = initval;
          b_next     = initval;
          c_next     = initval;
          state_next = WAITCLR;
        end
      end
      WAITCLR: begin
        // Hold off until the finish level drops so one message yields one result.
        if (!stream_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stream_ack = ce && !rst && (state_reg == IDLE) && stream_valid;
    fo_wen     = ce && !rst && (state_reg == OUT) && !fo_full;
    fo         = (state_reg == OUT) ? {b_reg, c_reg} : 64'd0;
    busy       = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_jhash_core.sv
// Randomised self-checking bench for jhash_core against a plain lookup3 reference.
module tb_jhash_core;

  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst, ce, stream_valid, stream_done, stream_ack, fo_wen, fo_full, busy;
  logic [31:0] initval, d0, d1, d2;
  logic [63:0] fo;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  jhash_core dut (
    .clk (clk), .rst (rst), .ce (ce), .initval (initval),
    .stream_data0 (d0), .stream_data1 (d1), .stream_data2 (d2),
    .stream_valid (stream_valid), .stream_done (stream_done), .stream_ack (stream_ack),
    .fo (fo), .fo_wen (fo_wen), .fo_full (fo_full), .busy (busy)
  );

  function automatic logic [31:0] rot(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // lookup3 as written in C: add a triple, mix(a,b,c); at the end final(a,b,c).
  function automatic logic [63:0] ref_hash(input logic [31:0] iv, input word_q_t w);
    logic [31:0] a, b, c;
    a = iv; b = iv; c = iv;
    for (int i = 0; i + 2 < w.size(); i += 3) begin
      a += w[i]; b += w[i+1]; c += w[i+2];
      a -= c; a ^= rot(c, 4);  c += b;
      b -= a; b ^= rot(a, 6);  a += c;
      c -= b; c ^= rot(b, 8);  b += a;
      a -= c; a ^= rot(c, 16); c += b;
      b -= a; b ^= rot(a, 19); a += c;
      c -= b; c ^= rot(b, 4);  b += a;
    end
    c ^= b; c -= rot(b, 14);
    a ^= c; a -= rot(c, 11);
    b ^= a; b -= rot(a, 25);
    c ^= b; c -= rot(b, 16);
    a ^= c; a -= rot(c, 4);
    b ^= a; b -= rot(a, 14);
    c ^= b; c -= rot(b, 24);
    return {b, c};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output bit ok, output int gap);
    ok = 1'b0;
    gap = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stream_ack === 1'b1) begin
        ok = 1'b1;
        gap = i;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic push_triple(inout word_q_t w, output bit ok, output int gap);
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    w.push_back(d0); w.push_back(d1); w.push_back(d2);
    stream_valid = 1'b1;
    wait_ack(ok, gap);
  endtask

  // Raise stream_done at k=0 and watch for the result strobe.
  task automatic collect(input int max_cyc, output bit got, output int lat,
                         output logic [63:0] res, output int nwen);
    got = 1'b0; lat = -1; res = '0; nwen = 0;
    stream_done = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      #1;
      if (fo_wen === 1'b1) begin
        nwen++;
        if (!got) begin got = 1'b1; lat = k; res = fo; end
      end
      @(negedge clk);
      if (got) stream_done = 1'b0;
      if (got && k >= lat + 4) break;
    end
    stream_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    initval = 32'h1234_5678;
    stream_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, stream_ack, fo_wen} !== 3'b000) begin
      errors++; $display("FAIL reset_outs: got %b expected 000", {busy, stream_ack, fo_wen});
    end
    checks++;
    if (fo !== 64'd0) begin errors++; $display("FAIL reset_fo: got %h expected 0", fo); end
    checks++;
    if ({dut.a_reg, dut.b_reg, dut.c_reg} !== {3{initval}}) begin
      errors++; $display("FAIL reset_abc: got %h expected %h", {dut.a_reg, dut.b_reg, dut.c_reg}, {3{initval}});
    end
    stream_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    $display("reset: initval=%h busy=%b", initval, busy);
  endtask

  task automatic test_empty();
    bit got; int lat, nwen; logic [63:0] res;
    initval = 32'd0;
    do_reset();
    collect(40, got, lat, res, nwen);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL empty_latency: got %0d expected 8", lat); end
    checks++;
    if (res !== 64'h0) begin errors++; $display("FAIL empty_fo: got %h expected 0", res); end
    checks++;
    if (nwen !== 1) begin errors++; $display("FAIL empty_wen_count: got %0d expected 1", nwen); end
    $display("empty message: fo=%h lat=%0d", res, lat);
  endtask

  task automatic test_single();
    bit ok, got; int gap, lat, nwen; logic [63:0] res, exp; word_q_t w;
    initval = 32'd0;
    do_reset();
    w = {};
    w.push_back(32'd1); w.push_back(32'd2); w.push_back(32'd3);
    d0 = 32'd1; d1 = 32'd2; d2 = 32'd3;
    stream_valid = 1'b1;
    wait_ack(ok, gap);
    stream_valid = 1'b0;
    checks++;
    if (!ok || gap != 0) begin errors++; $display("FAIL single_ack: got gap %0d expected 0", gap); end
    exp = ref_hash(32'd0, w);
    collect(60, got, lat, res, nwen);
    checks++;
    if (res !== exp) begin errors++; $display("FAIL single_fo: got %h expected %h", res, exp); end
    checks++;
    if (lat !== 14) begin errors++; $display("FAIL single_latency: got %0d expected 14", lat); end
    checks++;
    if (nwen !== 1) begin errors++; $display("FAIL single_wen_count: got %0d expected 1", nwen); end
    $display("single triple {1,2,3}: fo=%h", res);
  endtask

  task automatic test_back_to_back();
    bit ok, got; int gap, lat, nwen, acks, bad_gap; logic [63:0] res, exp; word_q_t w;
    initval = $urandom;
    do_reset();
    w = {}; acks = 0; bad_gap = 0;
    for (int t = 0; t < 4; t++) begin
      push_triple(w, ok, gap);
      if (ok) acks++;
      if (t > 0 && gap != 6) bad_gap++;
    end
    stream_valid = 1'b0;
    checks++;
    if (acks !== 4) begin errors++; $display("FAIL b2b_acks: got %0d expected 4", acks); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", bad_gap); end
    exp = ref_hash(initval, w);
    collect(60, got, lat, res, nwen);
    checks++;
    if (res !== exp || nwen != 1) begin
      errors++; $display("FAIL b2b_fo: got %h (wen %0d) expected %h (wen 1)", res, nwen, exp);
    end
    $display("back-to-back 4 triples: fo=%h", res);
  endtask

  task automatic test_fifo_full();
    bit ok; int gap, bad_wen, bad_fo; logic [63:0] exp; word_q_t w;
    initval = $urandom;
    do_reset();
    w = {};
    push_triple(w, ok, gap);
    stream_valid = 1'b0;
    exp = ref_hash(initval, w);
    fo_full = 1'b1;
    stream_done = 1'b1;
    bad_wen = 0; bad_fo = 0;
    for (int k = 0; k < 34; k++) begin
      #1;
      if (fo_wen !== 1'b0) bad_wen++;
      if (k >= 14 && fo !== exp) bad_fo++;
      @(negedge clk);
    end
    checks++;
    if (bad_wen != 0) begin errors++; $display("FAIL full_no_wen: got %0d strobes expected 0", bad_wen); end
    checks++;
    if (bad_fo != 0) begin errors++; $display("FAIL full_fo_stable: got %0d bad cycles expected 0", bad_fo); end
    fo_full = 1'b0;
    #1;
    checks++;
    if (fo_wen !== 1'b1 || fo !== exp) begin
      errors++; $display("FAIL full_release: got wen %b fo %h expected wen 1 fo %h", fo_wen, fo, exp);
    end
    @(negedge clk);
    stream_done = 1'b0;
    bad_wen = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (fo_wen !== 1'b0) bad_wen++;
      @(negedge clk);
    end
    checks++;
    if (bad_wen != 0) begin errors++; $display("FAIL full_dup_write: got %0d extra strobes expected 0", bad_wen); end
    $display("fifo full hold 20 cycles: fo=%h", exp);
  endtask

  task automatic test_ce_stall();
    bit ok, got; int gap, lat, nwen, frz_bad; logic [63:0] res, exp; word_q_t w;
    logic [31:0] sa, sb, sc; logic [2:0] ss;
    initval = $urandom;
    do_reset();
    w = {};
    push_triple(w, ok, gap);
    stream_valid = 1'b0;
    exp = ref_hash(initval, w);
    got = 1'b0; lat = -1; nwen = 0; frz_bad = 0; res = '0;
    sa = '0; sb = '0; sc = '0; ss = '0;
    stream_done = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 2) ce = 1'b0;
      if (k == 7) ce = 1'b1;
      #1;
      if (k == 2) begin sa = dut.a_reg; sb = dut.b_reg; sc = dut.c_reg; ss = dut.step_reg; end
      if (k > 2 && k < 7) begin
        if ({dut.a_reg, dut.b_reg, dut.c_reg, dut.step_reg} !== {sa, sb, sc, ss}) frz_bad++;
        if (stream_ack !== 1'b0 || fo_wen !== 1'b0) frz_bad++;
      end
      if (fo_wen === 1'b1) begin
        nwen++;
        if (!got) begin got = 1'b1; lat = k; res = fo; end
      end
      @(negedge clk);
      if (got) stream_done = 1'b0;
      if (got && k >= lat + 4) break;
    end
    stream_done = 1'b0;
    ce = 1'b1;
    @(negedge clk);
    checks++;
    if (frz_bad != 0) begin errors++; $display("FAIL ce_freeze: got %0d changes expected 0", frz_bad); end
    checks++;
    if (lat !== 19) begin errors++; $display("FAIL ce_latency: got %0d expected 19", lat); end
    checks++;
    if (res !== exp || nwen != 1) begin
      errors++; $display("FAIL ce_fo: got %h (wen %0d) expected %h (wen 1)", res, nwen, exp);
    end
    $display("ce stall 5 cycles: fo=%h lat=%0d", res, lat);
  endtask

  task automatic test_rst_mid_mix();
    bit ok, got; int gap, lat, nwen; logic [63:0] res, exp; word_q_t w;
    initval = 32'hdeadbeef;
    do_reset();
    w = {};
    push_triple(w, ok, gap);
    stream_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || dut.step_reg !== 3'd3) begin
      errors++; $display("FAIL rst_pre_busy: got busy %b step %0d expected busy 1 step 3", busy, dut.step_reg);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, stream_ack, fo_wen} !== 3'b000 || fo !== 64'd0) begin
      errors++; $display("FAIL rst_mid_outs: got %b fo %h expected 000 fo 0", {busy, stream_ack, fo_wen}, fo);
    end
    checks++;
    if ({dut.a_reg, dut.b_reg, dut.c_reg} !== {3{32'hdeadbeef}}) begin
      errors++; $display("FAIL rst_mid_abc: got %h expected %h", {dut.a_reg, dut.b_reg, dut.c_reg}, {3{32'hdeadbeef}});
    end
    @(negedge clk);
    w = {};
    for (int t = 0; t < 2; t++) push_triple(w, ok, gap);
    stream_valid = 1'b0;
    exp = ref_hash(32'hdeadbeef, w);
    collect(60, got, lat, res, nwen);
    checks++;
    if (res !== exp || nwen != 1) begin
      errors++; $display("FAIL rst_after_fo: got %h (wen %0d) expected %h (wen 1)", res, nwen, exp);
    end
    $display("reset mid-mix then 2 triples: fo=%h", res);
  endtask

  task automatic test_random();
    bit ok, got; int gap, lat, nwen, n, acks; logic [63:0] res, exp; word_q_t w;
    for (int m = 0; m < 6; m++) begin
      initval = $urandom;
      do_reset();
      w = {}; acks = 0;
      n = $urandom_range(0, 3);
      for (int t = 0; t < n; t++) begin
        push_triple(w, ok, gap);
        if (ok) acks++;
      end
      stream_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) repeat (10) @(negedge clk);
      exp = ref_hash(initval, w);
      collect(80, got, lat, res, nwen);
      checks++;
      if (res !== exp || nwen != 1 || acks != n) begin
        errors++;
        $display("FAIL random_msg%0d: got %h (wen %0d acks %0d) expected %h (wen 1 acks %0d)",
                 m, res, nwen, acks, exp, n);
      end
      $display("random msg %0d: triples=%0d fo=%h", m, n, res);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; initval = '0;
    d0 = '0; d1 = '0; d2 = '0;
    stream_valid = 1'b0; stream_done = 1'b0; fo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_ce_stall();
    test_rst_mid_mix();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
